rob_queue: RTL and testbench

Parametrised reorder buffer for the Tomasulo core, sitting between the issue stage and the register bank/memory commit path. It allocates an entry per issued instruction, records results broadcast on the common data bus (CDB) by tag, and retires entries strictly in program order. It generalises the fixed 8-entry ROB to configurable depth and width and adds operand lookup, store/branch classification and mispredict flush.

---
 rtl/tomasulo_pkg.sv | 31 +++
 rtl/rob_ptr.sv | 24 ++
 rtl/rob_queue.sv | 144 ++++++++++++++
 tb/tb_rob_queue.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: opcodes, reorder-buffer entry status
// and opcode classifiers used by the ROB and its neighbours.
package tomasulo_pkg;

    localparam int FUNC_W = 4;

    localparam logic [FUNC_W-1:0] OP_ADD   = 4'b0000;
    localparam logic [FUNC_W-1:0] OP_SUB   = 4'b0001;
    localparam logic [FUNC_W-1:0] OP_MUL   = 4'b0010;
    localparam logic [FUNC_W-1:0] OP_DIV   = 4'b0011;
    localparam logic [FUNC_W-1:0] OP_LOAD  = 4'b0100;
    localparam logic [FUNC_W-1:0] OP_STORE = 4'b0101;
    localparam logic [FUNC_W-1:0] OP_BEQ   = 4'b0110;
    localparam logic [FUNC_W-1:0] OP_BNEQ  = 4'b0111;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              mispredict;
        logic [FUNC_W-1:0] func;
    } rob_entry_t;

    function automatic logic is_branch(input logic [FUNC_W-1:0] f);
        return (f == OP_BEQ) || (f == OP_BNEQ);
    endfunction

    function automatic logic is_store(input logic [FUNC_W-1:0] f);
        return f == OP_STORE;
    endfunction

endpackage

// File: rtl/rob_ptr.sv
// Circular ROB pointer: advances by one and wraps modulo DEPTH,
// so non-power-of-two depths work.
module rob_ptr #(
    parameter int DEPTH = 8,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [TAG_W-1:0] ptr
);

    localparam logic [TAG_W-1:0] LAST = TAG_W'(DEPTH - 1);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (ptr == LAST) ? '0 : ptr + TAG_W'(1);
        end
    end

endmodule

// File: rtl/rob_queue.sv
// Parametrised reorder buffer: in-order allocate, CDB completion by tag,
// in-order retire. Define ROB_FLUSH_EN to enable mispredict flush.
module rob_queue
    import tomasulo_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int DATA_W = 16,
    parameter  int REG_W  = 4,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [3:0]        alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_mispredict,
    input  logic [TAG_W-1:0]  lk_tag,
    output logic              lk_done,
    output logic [DATA_W-1:0] lk_data,
    output logic              commit_valid,
    input  logic              commit_ready,
    output logic [TAG_W-1:0]  commit_tag,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_data,
    output logic              commit_wen,
    output logic              commit_is_store,
    output logic              flush,
    output logic [TAG_W:0]    count
);

    localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

    rob_entry_t        ent    [DEPTH];
    logic [REG_W-1:0]  rd_q   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   cnt;
    rob_entry_t       hd;
    logic             alloc_fire;
    logic             commit_fire;
    logic             cdb_hit;
    logic             lk_hit;
    logic             mp_in;

    assign hd          = ent[head];
    assign commit_valid = hd.busy && hd.done;
    assign commit_fire = commit_valid && commit_ready;

`ifdef ROB_FLUSH_EN
    assign flush = commit_fire && hd.mispredict;
    assign mp_in = cdb_mispredict && is_branch(ent[cdb_tag].func);
`else
    logic unused_mispredict;
    assign flush = 1'b0;
    assign mp_in = 1'b0;
    assign unused_mispredict = cdb_mispredict ^ hd.mispredict;
`endif

    // Readiness looks only at registered occupancy, never at this cycle's commit
    assign alloc_ready = (cnt < FULL) && !flush;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail;
    assign count       = cnt;

    assign cdb_hit = cdb_valid && ({1'b0, cdb_tag} < FULL)
                     && ent[cdb_tag].busy;

    assign commit_tag      = commit_valid ? head : '0;
    assign commit_rd       = commit_valid ? rd_q[head] : '0;
    assign commit_data     = commit_valid ? data_q[head] : '0;
    assign commit_is_store = commit_valid && is_store(hd.func);
    assign commit_wen      = commit_valid && !is_store(hd.func)
                             && !is_branch(hd.func);

    assign lk_hit  = ({1'b0, lk_tag} < FULL) && ent[lk_tag].busy
                     && ent[lk_tag].done;
    assign lk_done = lk_hit;
    assign lk_data = lk_hit ? data_q[lk_tag] : '0;

    rob_ptr #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_head (
        .clk     (clk1),
        .reset   (reset),
        .clear   (flush),
        .advance (commit_fire),
        .ptr     (head)
    );

    rob_ptr #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_tail (
        .clk     (clk1),
        .reset   (reset),
        .clear   (flush),
        .advance (alloc_fire),
        .ptr     (tail)
    );

    always_ff @(posedge clk1) begin
        if (reset || flush) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + (TAG_W+1)'(alloc_fire)
                       - (TAG_W+1)'(commit_fire);
        end
    end

    // Allocation is applied last so it overrides a same-cycle CDB write
    always_ff @(posedge clk1) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            if (cdb_hit) begin
                ent[cdb_tag].done       <= 1'b1;
                ent[cdb_tag].mispredict <= mp_in;
            end
            if (commit_fire) begin
                ent[head].busy <= 1'b0;
            end
            if (alloc_fire) begin
                ent[tail].busy       <= 1'b1;
                ent[tail].done       <= 1'b0;
                ent[tail].mispredict <= 1'b0;
                ent[tail].func       <= alloc_func;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (cdb_hit) begin
            data_q[cdb_tag] <= cdb_data;
        end
        if (alloc_fire) begin
            rd_q[tail] <= alloc_rd;
        end
    end

endmodule

// File: tb/tb_rob_queue.sv
// Bench for rob_queue at DEPTH=5: vector table, corner sequences and
// random traffic against a queue model. Honours ROB_FLUSH_EN.
`timescale 1ns/1ps
module tb_rob_queue;

    localparam int D  = 5;
    localparam int DW = 16;
    localparam int RW = 4;
    localparam int TW = 3;

    logic          clk1 = 1'b0;
    logic          reset = 1'b1;
    logic          alloc_valid = 1'b0;
    logic          alloc_ready;
    logic [3:0]    alloc_func = '0;
    logic [RW-1:0] alloc_rd = '0;
    logic [TW-1:0] alloc_tag;
    logic          cdb_valid = 1'b0;
    logic [TW-1:0] cdb_tag = '0;
    logic [DW-1:0] cdb_data = '0;
    logic          cdb_mispredict = 1'b0;
    logic [TW-1:0] lk_tag = '0;
    logic          lk_done;
    logic [DW-1:0] lk_data;
    logic          commit_valid;
    logic          commit_ready = 1'b0;
    logic [TW-1:0] commit_tag;
    logic [RW-1:0] commit_rd;
    logic [DW-1:0] commit_data;
    logic          commit_wen;
    logic          commit_is_store;
    logic          flush;
    logic [TW:0]   count;

    rob_queue #(.DEPTH(D), .DATA_W(DW), .REG_W(RW)) dut (
        .clk1            (clk1),
        .reset           (reset),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_func      (alloc_func),
        .alloc_rd        (alloc_rd),
        .alloc_tag       (alloc_tag),
        .cdb_valid       (cdb_valid),
        .cdb_tag         (cdb_tag),
        .cdb_data        (cdb_data),
        .cdb_mispredict  (cdb_mispredict),
        .lk_tag          (lk_tag),
        .lk_done         (lk_done),
        .lk_data         (lk_data),
        .commit_valid    (commit_valid),
        .commit_ready    (commit_ready),
        .commit_tag      (commit_tag),
        .commit_rd       (commit_rd),
        .commit_data     (commit_data),
        .commit_wen      (commit_wen),
        .commit_is_store (commit_is_store),
        .flush           (flush),
        .count           (count)
    );

    always #5 clk1 = ~clk1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: program-order queue of tags plus per-tag records
    int         mq[$];
    int         m_tail = 0;
    bit         m_done [8];
    bit         m_mp   [8];
    logic [3:0] m_func [8];
    logic [3:0] m_rd   [8];
    logic [15:0] m_data [8];

    function automatic bit m_busy(input int t);
        foreach (mq[i]) if (mq[i] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit e_cv();
        if (mq.size() == 0) return 1'b0;
        return m_done[mq[0]];
    endfunction

    function automatic bit e_flush();
`ifdef ROB_FLUSH_EN
        return e_cv() && commit_ready && m_mp[mq[0]];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_check();
        bit cv, fl, lkd;
        int h;
        cv = e_cv();
        fl = e_flush();
        chk("count", int'(count), mq.size());
        chk("alloc_ready", int'(alloc_ready), int'(mq.size() < D && !fl));
        chk("alloc_tag", int'(alloc_tag), m_tail);
        chk("commit_valid", int'(commit_valid), int'(cv));
        chk("flush", int'(flush), int'(fl));
        if (cv) begin
            h = mq[0];
            chk("commit_tag", int'(commit_tag), h);
            chk("commit_rd", int'(commit_rd), int'(m_rd[h]));
            chk("commit_data", int'(commit_data), int'(m_data[h]));
            chk("commit_is_store", int'(commit_is_store), int'(m_func[h] == 4'd5));
            chk("commit_wen", int'(commit_wen),
                int'(m_func[h] != 4'd5 && m_func[h] != 4'd6 && m_func[h] != 4'd7));
        end
        lkd = int'(lk_tag) < D && m_busy(int'(lk_tag)) && m_done[lk_tag];
        chk("lk_done", int'(lk_done), int'(lkd));
        if (lkd) chk("lk_data", int'(lk_data), int'(m_data[lk_tag]));
    endtask

    task automatic model_update();
        bit af, cf, fl;
        int t;
        if (reset) begin
            mq.delete();
            m_tail = 0;
            return;
        end
        fl = e_flush();
        af = alloc_valid && mq.size() < D && !fl;
        cf = e_cv() && commit_ready;
        t = int'(cdb_tag);
        if (cdb_valid && t < D && m_busy(t)) begin
            m_done[t] = 1'b1;
            m_data[t] = cdb_data;
`ifdef ROB_FLUSH_EN
            m_mp[t] = cdb_mispredict && (m_func[t] == 4'd6 || m_func[t] == 4'd7);
`endif
        end
        if (fl) begin
            mq.delete();
            m_tail = 0;
            return;
        end
        if (cf) void'(mq.pop_front());
        if (af) begin
            mq.push_back(m_tail);
            m_done[m_tail] = 1'b0;
            m_mp[m_tail]   = 1'b0;
            m_func[m_tail] = alloc_func;
            m_rd[m_tail]   = alloc_rd;
            m_tail = (m_tail + 1) % D;
        end
    endtask

    task automatic settle();
        @(negedge clk1);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk1);
        model_update();
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic drv(input bit av, input int fn, input int rd,
                       input bit cv, input int ct, input int cd,
                       input bit mp, input bit cr, input int lk);
        alloc_valid    = av;
        alloc_func     = 4'(fn);
        alloc_rd       = 4'(rd);
        cdb_valid      = cv;
        cdb_tag        = 3'(ct);
        cdb_data       = 16'(cd);
        cdb_mispredict = mp;
        commit_ready   = cr;
        lk_tag         = 3'(lk);
    endtask

    task automatic do_reset();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        bit av; int fn; int rd;
        bit cv; int ct; int cd;
        bit cr; int lk;
        int e_cnt; bit e_cv; int e_ctag; int e_crd; int e_cdata;
        bit e_wen; bit e_st; bit e_lkd; int e_lkdata;
    } vec_t;

    vec_t tv[9];

    initial begin
        foreach (m_done[i]) begin
            m_done[i] = 0; m_mp[i] = 0; m_func[i] = '0; m_rd[i] = '0; m_data[i] = '0;
        end
        tv[0] = '{1, 0, 1, 0, 0, 0,      0, 2, 0, 0, 0, 0, 0,      0, 0, 0, 0};
        tv[1] = '{1, 2, 2, 0, 0, 0,      0, 2, 1, 0, 0, 0, 0,      0, 0, 0, 0};
        tv[2] = '{1, 5, 3, 0, 0, 0,      0, 2, 2, 0, 0, 0, 0,      0, 0, 0, 0};
        tv[3] = '{0, 0, 0, 1, 2, 'h0033, 0, 2, 3, 0, 0, 0, 0,      0, 0, 0, 0};
        tv[4] = '{0, 0, 0, 1, 0, 'h0011, 0, 2, 3, 0, 0, 0, 0,      0, 0, 1, 'h33};
        tv[5] = '{0, 0, 0, 1, 1, 'h0022, 1, 2, 3, 1, 0, 1, 'h0011, 1, 0, 1, 'h33};
        tv[6] = '{0, 0, 0, 0, 0, 0,      1, 2, 2, 1, 1, 2, 'h0022, 1, 0, 1, 'h33};
        tv[7] = '{0, 0, 0, 0, 0, 0,      1, 2, 1, 1, 2, 3, 'h0033, 0, 1, 1, 'h33};
        tv[8] = '{0, 0, 0, 0, 0, 0,      0, 2, 0, 0, 0, 0, 0,      0, 0, 0, 0};

        do_reset();
        settle();
        chk("rst alloc_ready", int'(alloc_ready), 1);
        chk("rst alloc_tag", int'(alloc_tag), 0);
        chk("rst count", int'(count), 0);
        chk("rst commit_valid", int'(commit_valid), 0);
        chk("rst commit_fields", int'({commit_tag, commit_rd, commit_data}), 0);
        chk("rst wen_store_flush", int'({commit_wen, commit_is_store, flush}), 0);
        chk("rst lk", int'({lk_done, lk_data}), 0);
        tick();

        // In-order retire of out-of-order completions
        for (int i = 0; i < 9; i++) begin
            drv(tv[i].av, tv[i].fn, tv[i].rd, tv[i].cv, tv[i].ct, tv[i].cd,
                0, tv[i].cr, tv[i].lk);
            settle();
            chk($sformatf("v%0d count", i), int'(count), tv[i].e_cnt);
            chk($sformatf("v%0d commit_valid", i), int'(commit_valid), int'(tv[i].e_cv));
            if (tv[i].e_cv) begin
                chk($sformatf("v%0d commit_tag", i), int'(commit_tag), tv[i].e_ctag);
                chk($sformatf("v%0d commit_rd", i), int'(commit_rd), tv[i].e_crd);
                chk($sformatf("v%0d commit_data", i), int'(commit_data), tv[i].e_cdata);
                chk($sformatf("v%0d commit_wen", i), int'(commit_wen), int'(tv[i].e_wen));
                chk($sformatf("v%0d is_store", i), int'(commit_is_store), int'(tv[i].e_st));
            end
            chk($sformatf("v%0d lk_done", i), int'(lk_done), int'(tv[i].e_lkd));
            if (tv[i].e_lkd)
                chk($sformatf("v%0d lk_data", i), int'(lk_data), tv[i].e_lkdata);
            tick();
        end

        // Full queue, blocked allocate, then commit+alloc with tail wrap
        do_reset();
        for (int i = 0; i < D; i++) begin
            drv(1, 0, i, 0, 0, 0, 0, 0, 0);
            settle();
            chk("fill alloc_tag", int'(alloc_tag), i);
            chk("fill alloc_ready", int'(alloc_ready), 1);
            tick();
        end
        drv(1, 0, 9, 1, 0, 'h100, 0, 0, 0);
        settle();
        chk("full alloc_ready", int'(alloc_ready), 0);
        chk("full count", int'(count), 5);
        tick();
        drv(1, 0, 9, 1, 1, 'h101, 0, 1, 0);
        settle();
        chk("full commit alloc_ready", int'(alloc_ready), 0);
        chk("full commit valid", int'(commit_valid), 1);
        tick();
        drv(1, 0, 6, 0, 0, 0, 0, 1, 0);
        settle();
        chk("wrap alloc_tag0", int'(alloc_tag), 0);
        chk("wrap count4", int'(count), 4);
        chk("wrap commit_tag", int'(commit_tag), 1);
        tick();
        drv(1, 0, 7, 0, 0, 0, 0, 0, 0);
        settle();
        chk("wrap same-cycle count", int'(count), 4);
        chk("wrap alloc_tag1", int'(alloc_tag), 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("wrap refill count", int'(count), 5);
        chk("wrap refill ready", int'(alloc_ready), 0);
        chk("wrap tail", int'(alloc_tag), 2);
        tick();

        // Commit back-pressure holds the head steady
        do_reset();
        drv(1, 4, 7, 0, 0, 0, 0, 0, 0); cyc();
        drv(0, 0, 0, 1, 0, 'hA5A5, 0, 0, 0); cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("stall commit_valid", int'(commit_valid), 1);
            chk("stall fields", int'({commit_tag, commit_rd, commit_data}),
                int'({3'd0, 4'd7, 16'hA5A5}));
            chk("stall count", int'(count), 1);
            tick();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0); cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("stall drained", int'(count), 0);
        tick();

        // Stray CDB, lookup without forwarding, overwrite, alloc-vs-CDB
        drv(0, 0, 0, 1, 3, 'hBEEF, 0, 0, 3); cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 3);
        settle();
        chk("stray lk_done", int'(lk_done), 0);
        chk("stray count", int'(count), 0);
        tick();
        for (int i = 1; i <= 3; i++) begin
            drv(1, 0, i, 0, 0, 0, 0, 0, 3); cyc();
        end
        drv(0, 0, 0, 1, 1, 'h1111, 0, 0, 3);
        settle();
        chk("alloc3 lk_done", int'(lk_done), 0);
        tick();
        drv(0, 0, 0, 1, 1, 'h2222, 0, 0, 1); cyc();
        drv(1, 0, 4, 1, 4, 'h4444, 0, 1, 1);
        settle();
        chk("overwrite lk_data", int'(lk_data), 'h2222);
        chk("overwrite commit_data", int'(commit_data), 'h2222);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 4);
        settle();
        chk("alloc wins lk_done", int'(lk_done), 0);
        tick();

        // Mispredicted branch at the head
        do_reset();
        drv(1, 6, 5, 0, 0, 0, 0, 0, 0); cyc();
        drv(1, 0, 1, 0, 0, 0, 0, 0, 0); cyc();
        drv(1, 1, 2, 1, 0, 'h0001, 1, 0, 0); cyc();
        drv(0, 0, 0, 1, 1, 'h0010, 0, 0, 0); cyc();
        drv(0, 0, 0, 1, 2, 'h0020, 0, 1, 0);
        settle();
        chk("br commit_valid", int'(commit_valid), 1);
        chk("br commit_wen", int'(commit_wen), 0);
`ifdef ROB_FLUSH_EN
        chk("br flush", int'(flush), 1);
        chk("br alloc_ready", int'(alloc_ready), 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        settle();
        chk("post flush", int'(flush), 0);
        chk("post flush count", int'(count), 0);
        chk("post flush alloc_tag", int'(alloc_tag), 0);
        chk("post flush commit_valid", int'(commit_valid), 0);
        tick();
`else
        chk("br no flush", int'(flush), 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 1, 0);
        settle();
        chk("add commit", int'({commit_valid, commit_rd, commit_data}),
            int'({1'b1, 4'd1, 16'h0010}));
        tick();
        settle();
        chk("sub commit", int'({commit_valid, commit_rd, commit_data}),
            int'({1'b1, 4'd2, 16'h0020}));
        chk("sub no flush", int'(flush), 0);
        tick();
`endif

        // Reset with four busy entries
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, i, 0, 0, 0, 0, 0, 0); cyc();
        end
        drv(0, 0, 0, 1, 0, 'h55, 0, 0, 0); cyc();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("mid rst count", int'(count), 0);
        chk("mid rst commit_valid", int'(commit_valid), 0);
        chk("mid rst alloc_ready", int'(alloc_ready), 1);
        chk("mid rst alloc_tag", int'(alloc_tag), 0);
        chk("mid rst flush", int'(flush), 0);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int ct;
            int lk;
            if (mq.size() > 0 && $urandom_range(9) < 7)
                ct = mq[$urandom_range(mq.size() - 1)];
            else
                ct = $urandom_range(7);
            if (mq.size() > 0 && $urandom_range(1) == 1)
                lk = mq[$urandom_range(mq.size() - 1)];
            else
                lk = $urandom_range(7);
            drv($urandom_range(2) != 0, $urandom_range(7), $urandom_range(15),
                $urandom_range(1) == 1, ct, $urandom_range(16'hFFFF),
                $urandom_range(5) == 0, $urandom_range(9) < 7, lk);
            reset = ($urandom_range(499) == 0);
            cyc();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
